// File: rtl/intra_pred_gen8_pkg.sv
// intra_pred_pkg: mode constants, FSM state encoding and DC default for intra_pred_gen8
package intra_pred_pkg;
  localparam logic [1:0] MODE_VERT = 2'd0;
  localparam logic [1:0] MODE_HOR  = 2'd1;
  localparam logic [1:0] MODE_DC   = 2'd2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;
  function automatic int dc_default(input int w);
    return 1 << (w - 1);
  endfunction
endpackage

// File: rtl/intra_pred_gen8_if.sv
// intra_pred_gen8_if: predicted-row stream, master = predictor, slave = consumer
// pred_data (8*PIX_W, column 0 in LSBs), pred_row, pred_valid, pred_last from master; pred_ready from slave
interface intra_pred_gen8_if #(parameter int PIX_W = 8);
  logic [8*PIX_W-1:0] pred_data;
  logic [2:0] pred_row;
  logic pred_valid;
  logic pred_ready;
  logic pred_last;
  modport master(output pred_data, pred_row, pred_valid, pred_last, input pred_ready);
  modport slave(input pred_data, pred_row, pred_valid, pred_last, output pred_ready);
endinterface

// File: rtl/intra_pred_gen8_dc_sum.sv
// intra_dc_sum: combinational DC value from top/left reference sums, selected by availability
// in: top, left (8 pixels each, index 0 = column/row 0), top_avail, left_avail; out: dc
module intra_dc_sum #(
  parameter int PIX_W = 8,
  parameter logic [PIX_W-1:0] DC_DEFAULT = PIX_W'(1 << (PIX_W - 1))
) (
  input  logic [7:0][PIX_W-1:0] top,
  input  logic [7:0][PIX_W-1:0] left,
  input  logic top_avail,
  input  logic left_avail,
  output logic [PIX_W-1:0] dc
);
  localparam logic [PIX_W+3:0] R4 = 4;
  localparam logic [PIX_W+3:0] R8 = 8;
  logic [PIX_W+3:0] st, sl, sb, ts, ls;
  always_comb begin
    st = '0;
    sl = '0;
    for (int i = 0; i < 8; i++) begin
      st = st + (PIX_W+4)'(top[i]);
      sl = sl + (PIX_W+4)'(left[i]);
    end
    sb = (st + sl + R8) >> 4;
    ts = (st + R4) >> 3;
    ls = (sl + R4) >> 3;
    dc = top_avail && left_avail ? sb[PIX_W-1:0] :
         top_avail ? ts[PIX_W-1:0] :
         left_avail ? ls[PIX_W-1:0] : DC_DEFAULT;
  end
endmodule

// File: rtl/intra_pred_gen8.sv
// intra_pred_gen8: 8x8 intra predictor (VERT/DC, HOR when INTRA_HOR_EN is defined), one row per cycle
// in: CLK, RST_n (async low), flush, start, mode, top_avail, left_avail, REF_TOP0..7, REF_LEFT0..7 (INTRA_HOR_EN)
// out: pi (pred_data/pred_row/pred_valid/pred_last, pred_ready in), busy, done
module intra_pred_gen8 import intra_pred_pkg::*; #(
  parameter int PIX_W = 8,
  parameter logic [PIX_W-1:0] DC_DEFAULT = PIX_W'(dc_default(PIX_W))
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic flush,
  input  logic start,
  input  logic [1:0] mode,
  input  logic top_avail,
  input  logic left_avail,
  input  logic [PIX_W-1:0] REF_TOP0, REF_TOP1, REF_TOP2, REF_TOP3,
  input  logic [PIX_W-1:0] REF_TOP4, REF_TOP5, REF_TOP6, REF_TOP7,
`ifdef INTRA_HOR_EN
  input  logic [PIX_W-1:0] REF_LEFT0, REF_LEFT1, REF_LEFT2, REF_LEFT3,
  input  logic [PIX_W-1:0] REF_LEFT4, REF_LEFT5, REF_LEFT6, REF_LEFT7,
`endif
  intra_pred_gen8_if.master pi,
  output logic busy,
  output logic done
);
  logic [1:0] st, mode_q, m_in;
  logic [2:0] row;
  logic [7:0][PIX_W-1:0] top_q, left_q, left_in;
  logic [PIX_W-1:0] dc_q, dc;
  logic ta_q, la_q, la_in, fire, use_v, use_h;
`ifdef INTRA_HOR_EN
  assign left_in = {REF_LEFT7, REF_LEFT6, REF_LEFT5, REF_LEFT4, REF_LEFT3, REF_LEFT2, REF_LEFT1, REF_LEFT0};
  assign la_in = left_avail;
  assign m_in = mode;
`else
  logic unused_left;
  assign unused_left = left_avail;
  assign left_in = '0;
  assign la_in = 1'b0;
  assign m_in = mode == MODE_HOR ? MODE_VERT : mode;
`endif
  intra_dc_sum #(.PIX_W(PIX_W), .DC_DEFAULT(DC_DEFAULT)) u_dc (
    .top(top_q), .left(left_q), .top_avail(ta_q), .left_avail(la_q), .dc(dc)
  );
  assign fire = st == OUT && pi.pred_ready;
  assign use_v = mode_q == MODE_VERT && ta_q;
  assign use_h = mode_q == MODE_HOR && la_q;
  always_comb begin
    pi.pred_valid = st == OUT;
    pi.pred_row = pi.pred_valid ? row : 3'd0;
    pi.pred_last = pi.pred_valid && row == 3'd7;
    pi.pred_data = !pi.pred_valid ? '0 : use_v ? top_q : use_h ? {8{left_q[row]}} : {8{dc_q}};
    busy = st != IDLE;
    done = fire && row == 3'd7 && !flush;
  end
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      st <= IDLE;
      row <= '0;
      top_q <= '0;
      left_q <= '0;
      mode_q <= '0;
      ta_q <= 1'b0;
      la_q <= 1'b0;
      dc_q <= '0;
    end else if (flush) begin
      st <= IDLE;
      row <= '0;
    end else begin
      if (st == IDLE && start) begin
        st <= CALC;
        row <= '0;
        top_q <= {REF_TOP7, REF_TOP6, REF_TOP5, REF_TOP4, REF_TOP3, REF_TOP2, REF_TOP1, REF_TOP0};
        left_q <= left_in;
        mode_q <= m_in;
        ta_q <= top_avail;
        la_q <= la_in;
      end
      if (st == CALC) begin
        st <= OUT;
        dc_q <= dc;
      end
      if (fire) begin
        row <= row + 3'd1;
        if (row == 3'd7) st <= IDLE;
      end
    end
endmodule

// File: tb/tb_intra_pred_gen8.sv
// tb_intra_pred_gen8: directed self-checking bench for intra_pred_gen8
module tb_intra_pred_gen8;
  logic CLK = 0, RST_n = 0, flush = 0, start = 0, top_avail = 0, left_avail = 0;
  logic [1:0] mode = 0;
  logic [7:0] top [8];
`ifdef INTRA_HOR_EN
  logic [7:0] left [8];
`endif
  logic busy, done;
  logic [7:0][63:0] e;
  int checks = 0, failures = 0;
  intra_pred_gen8_if #(.PIX_W(8)) pi();
  always #5 CLK = ~CLK;
  intra_pred_gen8 dut (
    .CLK(CLK), .RST_n(RST_n), .flush(flush), .start(start), .mode(mode),
    .top_avail(top_avail), .left_avail(left_avail),
    .REF_TOP0(top[0]), .REF_TOP1(top[1]), .REF_TOP2(top[2]), .REF_TOP3(top[3]),
    .REF_TOP4(top[4]), .REF_TOP5(top[5]), .REF_TOP6(top[6]), .REF_TOP7(top[7]),
`ifdef INTRA_HOR_EN
    .REF_LEFT0(left[0]), .REF_LEFT1(left[1]), .REF_LEFT2(left[2]), .REF_LEFT3(left[3]),
    .REF_LEFT4(left[4]), .REF_LEFT5(left[5]), .REF_LEFT6(left[6]), .REF_LEFT7(left[7]),
`endif
    .pi(pi), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic fill(input logic [63:0] v);
    for (int r = 0; r < 8; r++) e[r] = v;
  endtask
  task automatic go(input logic [1:0] m, input logic ta, input logic la);
    @(negedge CLK);
    mode = m;
    top_avail = ta;
    left_avail = la;
    start = 1;
    @(negedge CLK);
    start = 0;
    chk("calc_busy", 64'(busy), 64'd1);
    chk("calc_valid", 64'(pi.pred_valid), 64'd0);
    @(negedge CLK);
  endtask
  task automatic drain(input int stall, input int poke);
    for (int r = 0; r < 8; r++) begin
      if (r == stall) begin
        pi.pred_ready = 0;
        repeat (3) begin
          chk("hold_valid", 64'(pi.pred_valid), 64'd1);
          chk("hold_row", 64'(pi.pred_row), 64'(r));
          chk("hold_data", pi.pred_data, e[r]);
          chk("hold_done", 64'(done), 64'd0);
          @(negedge CLK);
        end
        pi.pred_ready = 1;
      end
      if (r == poke) start = 1;
      chk("valid", 64'(pi.pred_valid), 64'd1);
      chk("row", 64'(pi.pred_row), 64'(r));
      chk("data", pi.pred_data, e[r]);
      chk("last", 64'(pi.pred_last), 64'(r == 7));
      chk("done", 64'(done), 64'(r == 7));
      @(negedge CLK);
      start = 0;
    end
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_valid", 64'(pi.pred_valid), 64'd0);
    chk("end_done", 64'(done), 64'd0);
  endtask
  task automatic set_top_ramp(input int step);
    for (int i = 0; i < 8; i++) top[i] = 8'((i + 1) * step);
  endtask
  task automatic set_top_const(input logic [7:0] v);
    for (int i = 0; i < 8; i++) top[i] = v;
  endtask
  initial begin
    pi.pred_ready = 1;
    set_top_ramp(10);
`ifdef INTRA_HOR_EN
    for (int i = 0; i < 8; i++) left[i] = 8'd50;
`endif
    @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(pi.pred_valid), 64'd0);
    chk("rst_data", pi.pred_data, 64'd0);
    chk("rst_row", 64'(pi.pred_row), 64'd0);
    chk("rst_last", 64'(pi.pred_last), 64'd0);
    RST_n = 1;
    fill(64'h50463C32281E140A);
    go(2'd0, 1, 0);
    drain(-1, -1);
    go(2'd0, 1, 0);
    drain(4, -1);
    go(2'd0, 1, 0);
    drain(-1, 2);
    @(negedge CLK);
    chk("poke_busy", 64'(busy), 64'd0);
    chk("poke_done", 64'(done), 64'd0);
`ifndef INTRA_HOR_EN
    go(2'd1, 1, 0);
    drain(-1, -1);
`endif
    fill({8{8'd45}});
    go(2'd3, 1, 0);
    drain(-1, -1);
    set_top_ramp(1);
    fill({8{8'd5}});
    go(2'd2, 1, 0);
    drain(-1, -1);
    set_top_const(8'd100);
`ifdef INTRA_HOR_EN
    fill({8{8'd75}});
`else
    fill({8{8'd100}});
`endif
    go(2'd2, 1, 1);
    drain(-1, -1);
    fill({8{8'd100}});
    go(2'd2, 1, 0);
    drain(-1, -1);
    fill({8{8'd128}});
    go(2'd2, 0, 0);
    drain(-1, -1);
    go(2'd0, 0, 0);
    drain(-1, -1);
`ifdef INTRA_HOR_EN
    fill({8{8'd50}});
    go(2'd0, 0, 1);
    drain(-1, -1);
    for (int i = 0; i < 8; i++) left[i] = 8'(i + 1);
    for (int r = 0; r < 8; r++) e[r] = {8{8'(r + 1)}};
    go(2'd1, 1, 1);
    drain(-1, -1);
    fill({8{8'd100}});
    go(2'd1, 1, 0);
    drain(-1, -1);
`endif
    set_top_ramp(10);
    fill(64'h50463C32281E140A);
    go(2'd0, 1, 0);
    repeat (3) @(negedge CLK);
    chk("fl_row", 64'(pi.pred_row), 64'd3);
    flush = 1;
    start = 1;
    @(negedge CLK);
    chk("fl_done", 64'(done), 64'd0);
    flush = 0;
    start = 0;
    chk("fl_valid", 64'(pi.pred_valid), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    flush = 1;
    start = 1;
    @(negedge CLK);
    flush = 0;
    start = 0;
    chk("fl_start_busy", 64'(busy), 64'd0);
    go(2'd0, 1, 0);
    drain(-1, -1);
    go(2'd0, 1, 0);
    @(negedge CLK);
    RST_n = 0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(pi.pred_valid), 64'd0);
    chk("arst_data", pi.pred_data, 64'd0);
    chk("arst_row", 64'(pi.pred_row), 64'd0);
    chk("arst_last", 64'(pi.pred_last), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge CLK);
    RST_n = 1;
    @(negedge CLK);
    chk("arst_idle", 64'(busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
